// File: rtl/fxp_sat_stage_pkg.sv
// Shared Q2.14 fixed-point definitions: default widths, saturation codes and the
// adder overflow/underflow flag pair used by both the adder and the saturation stage.
package fxp_sat_stage_pkg;

  localparam int FXP_DATA_WIDTH = 16;
  localparam int FXP_FRAC_WIDTH = 14;
  localparam int FXP_CNT_WIDTH  = 8;
  localparam int FXP_MAX_WIDTH  = 64;

  typedef struct packed {
    logic ovf;
    logic unf;
  } fxp_flags_t;

  typedef enum logic [1:0] {
    CLAMP_PASS = 2'd0,
    CLAMP_MAX  = 2'd1,
    CLAMP_MIN  = 2'd2
  } clamp_sel_e;

  // Most-negative code: sign bit alone. Callers truncate to their own width.
  function automatic logic [FXP_MAX_WIDTH-1:0] fxp_sat_min(input int unsigned width);
    return FXP_MAX_WIDTH'(1) << (width - 1);
  endfunction

  function automatic logic [FXP_MAX_WIDTH-1:0] fxp_sat_max(input int unsigned width);
    return fxp_sat_min(width) - FXP_MAX_WIDTH'(1);
  endfunction

  // Both flags set cannot come from a legal add; overflow is given priority.
  function automatic clamp_sel_e fxp_clamp_sel(input fxp_flags_t flags);
    if (flags.ovf) return CLAMP_MAX;
    if (flags.unf) return CLAMP_MIN;
    return CLAMP_PASS;
  endfunction

endpackage

// File: rtl/fxp_sat_stage_if.sv
// Upstream and downstream valid/ready handshake of the saturation stage.
// The stage connects through the slave modport; its environment uses master.
interface fxp_sat_stage_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ovf;
  logic                  in_unf;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sat;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_ovf, in_unf, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );

  modport master (
    output in_data, in_ovf, in_unf, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

endinterface

// File: rtl/fxp_clamp.sv
// Purely combinational clamp: replaces a wrapped adder sum with the most-positive
// or most-negative code according to the adder's overflow/underflow flags.
module fxp_clamp
  import fxp_sat_stage_pkg::*;
#(
  parameter int DATA_WIDTH = FXP_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] in_data,
  input  fxp_flags_t            in_flags,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat
);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(fxp_sat_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(fxp_sat_min(DATA_WIDTH));

  clamp_sel_e sel;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    out_data = in_data;
    out_sat  = in_flags.ovf | in_flags.unf;
    sel      = fxp_clamp_sel(in_flags);
    case (sel)
      CLAMP_MAX: out_data = SAT_MAX;
      CLAMP_MIN: out_data = SAT_MIN;
      default:   out_data = in_data;
    endcase
  end

endmodule

// File: rtl/fxp_sat_stage.sv
// Registered saturation stage behind the Q2.14 adder: clamp, 2-entry skid buffer
// (main + skid register), saturating overflow/underflow counters and sticky flag.
module fxp_sat_stage
  import fxp_sat_stage_pkg::*;
#(
  parameter int DATA_WIDTH = FXP_DATA_WIDTH,
  parameter int FRAC_WIDTH = FXP_FRAC_WIDTH,
  parameter int CNT_WIDTH  = FXP_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fxp_sat_stage_if.slave       bus,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] ovf_cnt,
  output logic [CNT_WIDTH-1:0] unf_cnt,
  output logic                 sat_sticky
);

  if (FRAC_WIDTH < 0 || FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_frac
    $error("fxp_sat_stage: FRAC_WIDTH must lie in [0, DATA_WIDTH)");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sat;
  } beat_t;

  fxp_flags_t            in_flags;
  logic [DATA_WIDTH-1:0] clamp_data;
  logic                  clamp_sat;
  beat_t                 in_beat;

  beat_t                 main_q, main_d;
  beat_t                 skid_q, skid_d;
  logic                  main_valid_q, main_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [CNT_WIDTH-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [CNT_WIDTH-1:0]  unf_cnt_q, unf_cnt_d;
  logic                  sat_sticky_q, sat_sticky_d;

  logic                  accept;
  logic                  drain;
  logic                  main_free;

  assign in_flags = '{ovf: bus.in_ovf, unf: bus.in_unf};

  fxp_clamp #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_clamp (
    .in_data  (bus.in_data),
    .in_flags (in_flags),
    .out_data (clamp_data),
    .out_sat  (clamp_sat)
  );

  assign in_beat = '{data: clamp_data, sat: clamp_sat};

  // in_ready depends only on registered state, never on out_ready.
  assign bus.in_ready = !skid_valid_q;
  assign accept       = bus.in_valid && !skid_valid_q;
  assign drain        = main_valid_q && bus.out_ready;
  assign main_free    = !main_valid_q || drain;

  always_comb begin : buffer_next
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (main_free) begin
      // A full skid blocks acceptance, so the older skid beat always goes first.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_d       = in_beat;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = in_beat;
    end
  end

  always_comb begin : status_next
    ovf_cnt_d    = ovf_cnt_q;
    unf_cnt_d    = unf_cnt_q;
    sat_sticky_d = sat_sticky_q;
    if (clr) begin
      ovf_cnt_d    = '0;
      unf_cnt_d    = '0;
      sat_sticky_d = 1'b0;
    end else if (accept) begin
      case (fxp_clamp_sel(in_flags))
        CLAMP_MAX: if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
        CLAMP_MIN: if (unf_cnt_q != '1) unf_cnt_d = unf_cnt_q + 1'b1;
        default:   ;
      endcase
      if (clamp_sat) sat_sticky_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      // NOTE: the data registers are reset as well, not only their valid bits,
      // because out_data/out_sat must read 0 out of reset.
      main_q       <= '0;
      skid_q       <= '0;
      ovf_cnt_q    <= '0;
      unf_cnt_q    <= '0;
      sat_sticky_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      ovf_cnt_q    <= ovf_cnt_d;
      unf_cnt_q    <= unf_cnt_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_q.data;
  assign bus.out_sat   = main_q.sat;
  assign ovf_cnt       = ovf_cnt_q;
  assign unf_cnt       = unf_cnt_q;
  assign sat_sticky    = sat_sticky_q;

endmodule

// File: tb/tb_fxp_sat_stage.sv
// Self-checking bench for fxp_sat_stage: directed cases plus random traffic checked
// against a queue-based FIFO model with clamp and counter rules.
module tb_fxp_sat_stage;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int CNT_MAX = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [CW-1:0] ovf_cnt;
  logic [CW-1:0] unf_cnt;
  logic          sat_sticky;

  fxp_sat_stage_if #(.DATA_WIDTH(DW)) bus ();

  fxp_sat_stage #(
    .DATA_WIDTH (DW),
    .FRAC_WIDTH (14),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr        (clr),
    .ovf_cnt    (ovf_cnt),
    .unf_cnt    (unf_cnt),
    .sat_sticky (sat_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: beats in flight as {sat, data}, oldest first; counters as plain ints.
  logic [DW:0] exp_q[$];
  int          m_ovf;
  int          m_unf;
  int          m_sticky;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_status();
    check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    check("unf_cnt", 32'(unf_cnt), 32'(m_unf));
    check("sat_sticky", 32'(sat_sticky), 32'(m_sticky));
  endtask

  // One cycle: drive at the negedge, check outputs 1 time unit later, advance model
  // across the coming posedge, return at the following negedge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit o, input bit u,
                      input bit ordy, input bit c, output bit acc);
    bit          drn;
    logic [DW:0] beat;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ovf    = o;
    bus.in_unf    = u;
    bus.out_ready = ordy;
    clr           = c;
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
    check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      beat = exp_q[0];
      check("out_data", 32'(bus.out_data), 32'(beat[DW-1:0]));
      check("out_sat", 32'(bus.out_sat), 32'(beat[DW]));
    end
    check_status();

    acc = v && (exp_q.size() < 2);
    drn = ordy && (exp_q.size() > 0);
    if (drn) void'(exp_q.pop_front());
    if (acc) begin
      if (o)      beat = {1'b1, 16'h7FFF};
      else if (u) beat = {1'b1, 16'h8000};
      else        beat = {1'b0, d};
      exp_q.push_back(beat);
    end
    if (c) begin
      m_ovf = 0;
      m_unf = 0;
      m_sticky = 0;
    end else if (acc) begin
      if (o)      m_ovf = (m_ovf < CNT_MAX) ? m_ovf + 1 : CNT_MAX;
      else if (u) m_unf = (m_unf < CNT_MAX) ? m_unf + 1 : CNT_MAX;
      if (o || u) m_sticky = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int idx;
    int cyc;
    bit o, u;
    int r;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ovf    = 1'b0;
    bus.in_unf    = 1'b0;
    bus.out_ready = 1'b0;
    m_ovf = 0;
    m_unf = 0;
    m_sticky = 0;

    // Reset state, with a beat presented during reset that must be discarded.
    #2;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h5555;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_sat", 32'(bus.out_sat), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_status();
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through, overflow clamp, underflow clamp.
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, a);
    step(1'b1, 16'h8001, 1'b1, 1'b0, 1'b1, 1'b0, a);
    step(1'b1, 16'h7FFE, 1'b0, 1'b1, 1'b1, 1'b0, a);
    idle(2);

    // Backpressure: 0x0001..0x0005, out_ready low for the first 3 cycles.
    idx = 1;
    for (cyc = 0; idx <= 5 && cyc < 50; cyc++) begin
      step(1'b1, 16'(idx), 1'b0, 1'b0, cyc >= 3, 1'b0, a);
      if (a) idx++;
    end
    check("bp_all_accepted", 32'(idx), 32'd6);
    idle(4);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Illegal flag pair: overflow wins.
    step(1'b1, 16'h1111, 1'b1, 1'b1, 1'b1, 1'b0, a);
    idle(1);

    // Counter saturation, then clr coincident with an overflow beat.
    for (int i = 0; i < 260; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b0, a);
    idle(1);
    check("ovf_cnt_saturated", 32'(ovf_cnt), 32'd255);
    step(1'b1, 16'h0F0F, 1'b1, 1'b0, 1'b1, 1'b1, a);
    idle(2);

    // Random traffic, including illegal flag pairs, stalls and occasional clr.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 7));
      o = (r == 0) || (r == 2);
      u = (r == 1) || (r == 2);
      step($urandom_range(0, 3) != 0, 16'($urandom), o, u,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, a);
    end
    idle(3);

    // Async reset mid-stream with two beats buffered.
    step(1'b1, 16'h0A0A, 1'b1, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 16'h0B0B, 1'b0, 1'b1, 1'b0, 1'b0, a);
    check("pre_rst_occupancy", 32'(exp_q.size()), 32'd2);
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h5555;
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("midrst_unf_cnt", 32'(unf_cnt), 32'd0);
    check("midrst_sticky", 32'(sat_sticky), 32'd0);
    exp_q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_sticky = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h0ABC, 1'b0, 1'b0, 1'b1, 1'b0, a);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fxp_sat_stage.md
# fxp_sat_stage

Registered saturation and output-buffer stage placed directly downstream of the Q2.14 fixed-point adder. Each cycle it can accept one sum together with the adder's overflow and underflow flags. When a flag is set, it clamps the sum to the most-positive or most-negative code, and it presents the result through a valid/ready interface with a 2-entry skid buffer. It also keeps saturating event counters and a sticky saturation flag for status readout.

## Interface
- DATA_WIDTH, 16: width of sum and output word (two's complement)
- FRAC_WIDTH, 14: fractional bits; carried for documentation and checks only, with no arithmetic effect
- CNT_WIDTH, 8: width of each event counter

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  DATA_WIDTH  raw sum from adder
- in_ovf  in  1  adder overflow flag (pos+pos wrapped negative)
- in_unf  in  1  adder underflow flag (neg+neg wrapped positive)
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- out_data  out  DATA_WIDTH  saturated result
- out_sat  out  1  this output beat was clamped
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts
- clr  in  1  synchronous clear of counters and sticky flag
- ovf_cnt  out  CNT_WIDTH  accepted overflow beats, saturating
- unf_cnt  out  CNT_WIDTH  accepted underflow beats, saturating
- sat_sticky  out  1  set by any clamped beat, cleared by clr

## Operation
- Accept: a beat is accepted when in_valid && in_ready.
- Clamp rule:
  - in_ovf=1: output is MAX = 0 followed by all ones (0x7FFF at 16 bits).
  - else in_unf=1: output is MIN = 1 followed by all zeros (0x8000).
  - else: output is in_data unchanged.
  - out_sat = in_ovf | in_unf.
- Both flags set is an illegal input. Overflow takes precedence: output MAX, only ovf_cnt increments.
- Buffer: main register (drives out_*) plus one skid register.
  - in_ready = !skid_valid.
  - Accepted beat with main empty, or main being drained this cycle and skid empty: goes to main.
  - Accepted beat with main full and not draining: goes to skid.
  - Main drained while skid full: skid moves to main and skid empties.
- Ordering is strict FIFO. No beat is dropped or duplicated.
- Counters: on an accepted beat, increment ovf_cnt (if in_ovf) or unf_cnt (else if in_unf). Each counter holds at all-ones and does not wrap. sat_sticky sets on any accepted clamped beat.
- clr: zeroes both counters and sat_sticky next edge.
  - clr wins over a same-cycle increment: that beat is not counted and the sticky is not set.
  - clr does not affect the data path.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_sat=0, skid empty, ovf_cnt=0, unf_cnt=0, sat_sticky=0.
  - in_ready reads 1 while in reset, since the skid is empty.
  - Beats presented while rst_n is low are discarded.
- Latency: a beat accepted at edge N appears on out_* after edge N when main was empty. Latency is exactly 1 cycle.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Output hold: while out_valid && !out_ready, out_data and out_sat are stable.
- in_ready changes only on clock edges (it is a function of registered state). in_ready has no combinational path from out_ready.
- Counters and sticky update on the same edge that accepts the beat.
- Reset asserted mid-stream: all buffered beats are lost. After deassertion the first accepted beat again has 1-cycle latency.

## Structure
- Shared fixed-point package holds:
  - DATA_WIDTH/FRAC_WIDTH defaults
  - MAX/MIN saturation constants as functions of width
  - the flag-pair typedef (ovf, unf), reused by the adder and this stage
- Natural sub-module: fxp_clamp, the purely combinational clamp (data and flags in, data and sat out). It is instantiated once, before the skid buffer.
- Buffer control and counters live in the top module.

## Test plan
- Pass-through: in_data=0x1234, flags 0, out_ready=1 -> one cycle later out_data=0x1234, out_sat=0, counters stay 0.
- Overflow clamp: in_data=0x8001, in_ovf=1 -> out_data=0x7FFF, out_sat=1, ovf_cnt=1, sat_sticky=1. Underflow: in_data=0x7FFE, in_unf=1 -> out_data=0x8000, unf_cnt=1.
- Backpressure: stream 0x0001..0x0005 back-to-back, out_ready=0 for 3 cycles.
  - Required: in_ready drops after 2 accepted beats, out_data holds 0x0001.
  - On release, the output sequence is 0x0001..0x0005 in order with no gaps or repeats.
- Counter saturation and clr: 260 overflow beats with CNT_WIDTH=8 -> ovf_cnt=255 and held. Then clr coincident with another ovf beat -> ovf_cnt=0, sat_sticky=0, and that beat's data still exits as 0x7FFF.
- Illegal flags: in_ovf=in_unf=1 -> out_data=0x7FFF, ovf_cnt increments, unf_cnt unchanged.
- Async reset mid-stream: assert rst_n low between edges with 2 beats buffered.
  - Required: out_valid=0 immediately, counters 0, in_ready=1.
  - After release, a new beat 0x0ABC appears 1 cycle after acceptance.
